// File: rtl/regfile_port_sequencer.sv
// Sequencer that owns the single shared register-file port: two reads per
// operand request, with ALU writebacks slotted in whenever the port is idle.
module regfile_port_sequencer #(
  parameter int          WIDTH     = 16,
  parameter int          ASEL      = 6,
  parameter logic [1:0]  MODE_NONE = 2'b00,
  parameter logic [1:0]  MODE_IN   = 2'b01,
  parameter logic [1:0]  MODE_OUT  = 2'b10
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ASEL-1:0]  req_src1,
  input  logic [ASEL-1:0]  req_src2,
  input  logic [ASEL-1:0]  req_dest,
  input  logic             req_one_src,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [ASEL-1:0]  op_dest,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [ASEL-1:0]  wb_reg,
  input  logic [WIDTH-1:0] wb_data,
  output logic [ASEL-1:0]  rf_sel,
  output logic [1:0]       rf_mode,
  output logic [WIDTH-1:0] rf_wdata,
  input  logic [WIDTH-1:0] rf_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    CAP2,
    PRESENT
  } state_e;

  state_e           state_q, state_d;
  logic [ASEL-1:0]  src1_q, src1_d;
  logic [ASEL-1:0]  src2_q, src2_d;
  logic [ASEL-1:0]  dest_q, dest_d;
  logic             one_src_q, one_src_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_valid_q, op_valid_d;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      src1_q     <= '0;
      src2_q     <= '0;
      dest_q     <= '0;
      one_src_q  <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      dest_q     <= dest_d;
      one_src_q  <= one_src_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
    end
  end

  // rf_rdata is registered by the register file, so each read's data is
  // captured one state after the state that issued it.
  always_comb begin
    state_d    = state_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    dest_d     = dest_q;
    one_src_d  = one_src_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_valid_d = op_valid_q;
    req_ready  = 1'b0;
    wb_ready   = 1'b0;
    rf_sel     = '0;
    rf_mode    = MODE_NONE;
    rf_wdata   = '0;

    case (state_q)
      IDLE: begin
        wb_ready = 1'b1;
        if (wb_valid) begin
          rf_mode  = MODE_IN;
          rf_sel   = wb_reg;
          rf_wdata = wb_data;
        end else begin
          req_ready = 1'b1;
          if (req_valid) begin
            src1_d    = req_src1;
            src2_d    = req_src2;
            dest_d    = req_dest;
            one_src_d = req_one_src;
            state_d   = RD1;
          end
        end
      end
      RD1: begin
        rf_mode = MODE_OUT;
        rf_sel  = src1_q;
        state_d = one_src_q ? CAP2 : RD2;
      end
      RD2: begin
        rf_mode = MODE_OUT;
        rf_sel  = src2_q;
        op_a_d  = rf_rdata;
        state_d = CAP2;
      end
      CAP2: begin
        if (one_src_q) begin
          op_a_d = rf_rdata;
          op_b_d = '0;
        end else begin
          op_b_d = rf_rdata;
        end
        op_valid_d = 1'b1;
        state_d    = PRESENT;
      end
      PRESENT: begin
        // Port is unused while the ALU holds off, so writebacks may proceed.
        wb_ready = 1'b1;
        if (wb_valid) begin
          rf_mode  = MODE_IN;
          rf_sel   = wb_reg;
          rf_wdata = wb_data;
        end
        if (op_ready) begin
          op_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign op_valid = op_valid_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_dest  = dest_q;

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Randomized bench for regfile_port_sequencer with a behavioural register-file
// model and a transaction-level reference of expected operands and timing.
module tb_regfile_port_sequencer;

  localparam int WIDTH = 16;
  localparam int ASEL  = 6;

  logic             clk;
  logic             clear;
  logic             req_valid;
  logic             req_ready;
  logic [ASEL-1:0]  req_src1;
  logic [ASEL-1:0]  req_src2;
  logic [ASEL-1:0]  req_dest;
  logic             req_one_src;
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [ASEL-1:0]  op_dest;
  logic             wb_valid;
  logic             wb_ready;
  logic [ASEL-1:0]  wb_reg;
  logic [WIDTH-1:0] wb_data;
  logic [ASEL-1:0]  rf_sel;
  logic [1:0]       rf_mode;
  logic [WIDTH-1:0] rf_wdata;
  logic [WIDTH-1:0] rf_rdata;

  logic [WIDTH-1:0] rfMem  [64];
  logic [WIDTH-1:0] refMem [64];

  int checks = 0;
  int errors = 0;

  regfile_port_sequencer dut (
    .clk         (clk),
    .clear       (clear),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .req_dest    (req_dest),
    .req_one_src (req_one_src),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_dest     (op_dest),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .rf_sel      (rf_sel),
    .rf_mode     (rf_mode),
    .rf_wdata    (rf_wdata),
    .rf_rdata    (rf_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file with a registered read port, as seen by the sequencer.
  always @(posedge clk) begin
    if (rf_mode == 2'b01) rfMem[rf_sel] <= rf_wdata;
    else if (rf_mode == 2'b10) rf_rdata <= rfMem[rf_sel];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one writeback in a cycle where the port is free; the reference
  // memory takes the new value once the write is accepted.
  task automatic applyWriteback(input logic [ASEL-1:0] r, input logic [WIDTH-1:0] d);
    wb_valid = 1'b1;
    wb_reg   = r;
    wb_data  = d;
    #1;
    checkOutput("wb_ready", {31'b0, wb_ready}, 32'd1);
    checkOutput("wb_mode", {30'b0, rf_mode}, 32'd1);
    checkOutput("wb_sel", {26'b0, rf_sel}, {26'b0, r});
    checkOutput("wb_wdata", {16'b0, rf_wdata}, {16'b0, d});
    checkOutput("wb_req_ready", {31'b0, req_ready}, 32'd0);
    refMem[r] = d;
    tick();
    wb_valid = 1'b0;
  endtask

  // Follows a request from its acceptance edge to the ALU handshake.
  task automatic waitOperands(input logic [ASEL-1:0] s1, input logic [ASEL-1:0] s2,
                              input logic [ASEL-1:0] dst, input logic one,
                              input int hold, input int wbMask,
                              input logic [ASEL-1:0] wr, input logic [WIDTH-1:0] wd);
    logic [WIDTH-1:0] expA;
    logic [WIDTH-1:0] expB;
    logic [7:0]       modes;
    int               lat;
    expA  = refMem[s1];
    expB  = one ? '0 : refMem[s2];
    modes = '0;
    lat   = 0;
    while (!op_valid && lat < 8) begin
      modes = {modes[5:0], rf_mode};
      checkOutput("busy_req_ready", {31'b0, req_ready}, 32'd0);
      checkOutput("busy_wb_ready", {31'b0, wb_ready}, 32'd0);
      tick();
      lat++;
    end
    checkOutput("latency", lat, one ? 32'd2 : 32'd3);
    checkOutput("mode_seq", {24'b0, modes}, one ? 32'h08 : 32'h28);
    checkOutput("op_a", {16'b0, op_a}, {16'b0, expA});
    checkOutput("op_b", {16'b0, op_b}, {16'b0, expB});
    checkOutput("op_dest", {26'b0, op_dest}, {26'b0, dst});
    for (int h = 0; h < hold; h++) begin
      checkOutput("hold_valid", {31'b0, op_valid}, 32'd1);
      checkOutput("hold_req_ready", {31'b0, req_ready}, 32'd0);
      checkOutput("hold_op_a", {16'b0, op_a}, {16'b0, expA});
      checkOutput("hold_op_b", {16'b0, op_b}, {16'b0, expB});
      if (wbMask[h]) applyWriteback(wr, wd);
      else tick();
    end
    op_ready = 1'b1;
    #1;
    checkOutput("final_valid", {31'b0, op_valid}, 32'd1);
    if (wbMask[hold]) applyWriteback(wr, wd);
    else tick();
    op_ready = 1'b0;
    #1;
    checkOutput("drop_valid", {31'b0, op_valid}, 32'd0);
    checkOutput("idle_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [ASEL-1:0] s1, input logic [ASEL-1:0] s2,
                               input logic [ASEL-1:0] dst, input logic one,
                               input int hold, input int wbMask,
                               input logic [ASEL-1:0] wr, input logic [WIDTH-1:0] wd);
    req_valid   = 1'b1;
    req_src1    = s1;
    req_src2    = s2;
    req_dest    = dst;
    req_one_src = one;
    #1;
    checkOutput("accept_ready", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    waitOperands(s1, s2, dst, one, hold, wbMask, wr, wd);
  endtask

  initial begin
    clear       = 1'b1;
    req_valid   = 1'b0;
    req_src1    = '0;
    req_src2    = '0;
    req_dest    = '0;
    req_one_src = 1'b0;
    op_ready    = 1'b0;
    wb_valid    = 1'b0;
    wb_reg      = '0;
    wb_data     = '0;
    #12;
    checkOutput("rst_op_valid", {31'b0, op_valid}, 32'd0);
    checkOutput("rst_op_a", {16'b0, op_a}, 32'd0);
    checkOutput("rst_op_b", {16'b0, op_b}, 32'd0);
    checkOutput("rst_op_dest", {26'b0, op_dest}, 32'd0);
    checkOutput("rst_rf_mode", {30'b0, rf_mode}, 32'd0);
    checkOutput("rst_rf_sel", {26'b0, rf_sel}, 32'd0);
    checkOutput("rst_rf_wdata", {16'b0, rf_wdata}, 32'd0);
    clear = 1'b0;
    tick();

    for (int i = 0; i < 64; i++) applyWriteback(i[ASEL-1:0], WIDTH'($urandom));
    applyWriteback(6'd1, 16'h0001);
    applyWriteback(6'd2, 16'h8000);
    applyWriteback(6'd3, 16'hffff);

    $display("[TB] two-source and single-source reads");
    applyStimulus(6'd1, 6'd2, 6'd5, 1'b0, 0, 0, 6'd0, 16'h0);
    applyStimulus(6'd3, 6'd9, 6'd4, 1'b1, 0, 0, 6'd0, 16'h0);

    $display("[TB] writeback priority over a pending request");
    req_valid = 1'b1;
    req_src1  = 6'd10;
    req_src2  = 6'd10;
    req_dest  = 6'd11;
    req_one_src = 1'b0;
    applyWriteback(6'd10, 16'h1234);
    applyStimulus(6'd10, 6'd10, 6'd11, 1'b0, 0, 0, 6'd0, 16'h0);

    $display("[TB] writeback while operands wait");
    applyStimulus(6'd1, 6'd2, 6'd6, 1'b0, 5, 32'b000100, 6'd7, 16'hbeef);
    applyStimulus(6'd7, 6'd7, 6'd8, 1'b0, 0, 0, 6'd0, 16'h0);

    $display("[TB] asynchronous reset during the second read");
    req_valid = 1'b1;
    req_src1  = 6'd1;
    req_src2  = 6'd2;
    req_dest  = 6'd3;
    req_one_src = 1'b0;
    #1;
    tick();
    req_valid = 1'b0;
    tick();
    #1;
    clear = 1'b1;
    #1;
    checkOutput("midrst_op_valid", {31'b0, op_valid}, 32'd0);
    checkOutput("midrst_rf_mode", {30'b0, rf_mode}, 32'd0);
    checkOutput("midrst_op_a", {16'b0, op_a}, 32'd0);
    checkOutput("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("midrst_wb_ready", {31'b0, wb_ready}, 32'd1);
    #1;
    clear = 1'b0;
    tick();
    applyStimulus(6'd2, 6'd1, 6'd9, 1'b0, 0, 0, 6'd0, 16'h0);

    $display("[TB] backpressure");
    applyStimulus(6'd3, 6'd1, 6'd12, 1'b0, 10, 0, 6'd0, 16'h0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 40; n++) begin
      logic [ASEL-1:0] s1;
      logic [ASEL-1:0] s2;
      int              hold;
      s1   = ASEL'($urandom);
      s2   = ($urandom_range(0, 3) == 0) ? s1 : ASEL'($urandom);
      hold = $urandom_range(0, 4);
      if ($urandom_range(0, 2) == 0)
        applyWriteback(ASEL'($urandom), WIDTH'($urandom));
      else
        applyStimulus(s1, s2, ASEL'($urandom), 1'($urandom), hold,
                      int'($urandom_range(0, 31)), ASEL'($urandom), WIDTH'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
